// File: rtl/lane_drain_sched.sv
// Round-robin drain scheduler: pops bounded bursts from per-lane FIFOs and merges
// them into one valid/ready stream tagged with the source lane, never overrunning its 2-entry buffer.
module lane_drain_sched #(
  parameter  int NUM_LANES = 4,
  parameter  int DATA_W    = 16,
  parameter  int BURST_MAX = 4,
  localparam int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic                        hs_clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_LANES-1:0]        lane_mask,
  input  logic [NUM_LANES-1:0]        fifo_empty,
  input  logic [NUM_LANES*DATA_W-1:0] fifo_rdata,
  output logic [NUM_LANES-1:0]        fifo_pop,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [LANE_W-1:0]           out_lane,
  output logic                        busy
);
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                        state_q, state_d;
  logic [LANE_W-1:0]             grant_q, grant_d;
  logic [LANE_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]              burst_cnt_q, burst_cnt_d;
  logic                          inflight_q, inflight_d;
  logic [LANE_W-1:0]             fl_lane_q, fl_lane_d;
  logic [1:0][DATA_W-1:0]        buf_data_q, buf_data_d;
  logic [1:0][LANE_W-1:0]        buf_lane_q, buf_lane_d;
  logic                          rd_ptr_q, rd_ptr_d;
  logic                          wr_ptr_q, wr_ptr_d;
  logic [1:0]                    occ_q, occ_d;

  logic [NUM_LANES-1:0]          eligible;
  logic                          any_elig;
  logic [LANE_W-1:0]             first_elig;
  logic                          deq;
  logic                          credit;
  logic                          pop;
  logic [2:0]                    committed;

  function automatic logic [LANE_W-1:0] wrap_add(input logic [LANE_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NUM_LANES) s = s - NUM_LANES;
    return s[LANE_W-1:0];
  endfunction

  assign eligible  = lane_mask & ~fifo_empty;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf_data_q[rd_ptr_q];
  assign out_lane  = buf_lane_q[rd_ptr_q];
  assign deq       = out_valid && out_ready;
  assign busy      = (state_q != IDLE) || inflight_q || (occ_q != 2'd0);

  // Slots already spoken for once this cycle's dequeue is retired.
  assign committed = 3'(occ_q) + 3'(inflight_q) - 3'(deq);
  assign credit    = (committed < 3'd2);

  // Descending scan so the smallest offset from rr_ptr wins.
  always_comb begin
    any_elig   = 1'b0;
    first_elig = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (eligible[wrap_add(rr_ptr_q, k)]) begin
        any_elig   = 1'b1;
        first_elig = wrap_add(rr_ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    pop         = 1'b0;
    fifo_pop    = '0;
    case (state_q)
      IDLE: begin
        if (en && any_elig) begin
          grant_d     = first_elig;
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        if (!en || !eligible[grant_q] || burst_cnt_q == CNT_W'(BURST_MAX)) begin
          state_d  = IDLE;
          rr_ptr_d = wrap_add(grant_q, 1);
        end else if (credit) begin
          pop         = !rst;
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) fifo_pop[grant_q] = 1'b1;
  end

  // Read data lands one cycle after the pop; capture it into the buffer tail.
  always_comb begin
    buf_data_d = buf_data_q;
    buf_lane_d = buf_lane_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = pop;
    fl_lane_d  = grant_q;
    if (inflight_q) begin
      buf_data_d[wr_ptr_q] = fifo_rdata[int'(fl_lane_q)*DATA_W +: DATA_W];
      buf_lane_d[wr_ptr_q] = fl_lane_q;
      wr_ptr_d             = ~wr_ptr_q;
    end
    if (deq) rd_ptr_d = ~rd_ptr_q;
    occ_d = occ_q + 2'(inflight_q) - 2'(deq);
  end

  always_ff @(posedge hs_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      inflight_q  <= 1'b0;
      fl_lane_q   <= '0;
      buf_data_q  <= '0;
      buf_lane_q  <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      inflight_q  <= inflight_d;
      fl_lane_q   <= fl_lane_d;
      buf_data_q  <= buf_data_d;
      buf_lane_q  <= buf_lane_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
    end
  end
endmodule

// File: tb/tb_lane_drain_sched.sv
// Bench for lane_drain_sched: behavioural lane FIFOs feed a scoreboard of popped words,
// a monitor checks every output beat, plus directed scenarios and a random soak.
module tb_lane_drain_sched;
  localparam int NL = 4;
  localparam int DW = 16;
  localparam int BM = 4;

  logic            hs_clk = 1'b0;
  logic            rst, en, out_valid, out_ready, busy;
  logic [NL-1:0]   lane_mask, fifo_empty, fifo_pop;
  logic [NL*DW-1:0] fifo_rdata;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_lane;

  typedef struct packed { logic [1:0] lane; logic [DW-1:0] data; } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] lane_q[NL][$];
  int            lane_ord[$];
  bit            chk_ord;
  int            n_chk, n_err, pop_total, deq_total, last_pop_lane;
  int            pop_cnt[NL];
  logic [DW-1:0] word_id;
  bit            pop_vld_s;
  int            pop_lane_s;
  bit            prev_hold;
  logic [DW-1:0] prev_data;
  logic [1:0]    prev_lane;
  int            mon_l, ord_next, rl;
  exp_t          mon_e;

  always #5 hs_clk = ~hs_clk;

  lane_drain_sched #(.NUM_LANES(NL), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .hs_clk(hs_clk), .rst(rst), .en(en), .lane_mask(lane_mask), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_pop(fifo_pop), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lane(out_lane), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle, scores dequeues, legalises pops, records popped words.
  always @(negedge hs_clk) begin
    if (rst) begin
      chk("pop_in_rst", 64'(fifo_pop), 0);
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (exp_q.size() > 0) chk("busy_outstanding", 64'(busy), 1);
      if (prev_hold) begin
        chk("hold_valid", 64'(out_valid), 1);
        chk("hold_data", 64'(out_data), 64'(prev_data));
        chk("hold_lane", 64'(out_lane), 64'(prev_lane));
      end
      if (out_valid && out_ready) begin
        deq_total++;
        chk("out_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(mon_e.data));
          chk("out_lane", 64'(out_lane), 64'(mon_e.lane));
        end
        if (chk_ord) begin
          ord_next = (lane_ord.size() != 0) ? lane_ord.pop_front() : 99;
          chk("ord_lane", 64'(out_lane), 64'(ord_next));
        end
      end
      if (fifo_pop != '0) begin
        mon_l = 0;
        for (int i = 0; i < NL; i++) if (fifo_pop[i]) mon_l = i;
        chk("pop_legal", 64'($onehot(fifo_pop) && en && lane_mask[mon_l] && !fifo_empty[mon_l]
                             && lane_q[mon_l].size() > 0), 1);
        if (lane_q[mon_l].size() > 0) begin
          mon_e.lane = 2'(mon_l);
          mon_e.data = lane_q[mon_l][0];
          exp_q.push_back(mon_e);
        end
        pop_vld_s = 1'b1; pop_lane_s = mon_l;
        pop_total++; pop_cnt[mon_l]++; last_pop_lane = mon_l;
        chk("credit", 64'(exp_q.size() <= 2), 1);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_lane = out_lane;
    end
  end

  // Lane FIFO model: read data appears the cycle after a pop, other lanes carry noise.
  always @(posedge hs_clk) begin
    #2;
    for (int i = 0; i < NL; i++) fifo_rdata[i*DW +: DW] = DW'($urandom);
    if (pop_vld_s && lane_q[pop_lane_s].size() > 0)
      fifo_rdata[pop_lane_s*DW +: DW] = lane_q[pop_lane_s].pop_front();
    pop_vld_s = 1'b0;
    for (int i = 0; i < NL; i++) fifo_empty[i] = (lane_q[i].size() == 0);
  end

  task automatic tick();
    @(posedge hs_clk);
    #1;
  endtask

  task automatic push_words(input int l, input int n);
    for (int i = 0; i < n; i++) begin
      lane_q[l].push_back(word_id);
      word_id++;
    end
  endtask

  task automatic wait_drain(input int bound);
    bit done;
    int left;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge hs_clk);
      left = 0;
      for (int l = 0; l < NL; l++) left += lane_q[l].size();
      done = (exp_q.size() == 0) && !busy && (left == 0);
    end
    chk("drain", 64'(done), 1);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; out_ready = 1'b1; lane_mask = '1;
    tick();
    for (int i = 0; i < NL; i++) begin lane_q[i].delete(); pop_cnt[i] = 0; end
    pop_total = 0; deq_total = 0;
    @(negedge hs_clk);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_pop", 64'(fifo_pop), 0);
    chk("rst_data", 64'(out_data), 0);
    chk("rst_lane", 64'(out_lane), 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic ov[8], bz[8];
    int   cnt[NL], r, n, left, p;
    rst = 1'b1; en = 1'b0; out_ready = 1'b1; lane_mask = '1;
    fifo_empty = '1; fifo_rdata = '0; word_id = '0; chk_ord = 1'b0;
    n_chk = 0; n_err = 0;
    do_reset();

    // Single lane, three words: latency and busy profile.
    push_words(2, 3);
    tick();
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge hs_clk);
      ov[k] = out_valid; bz[k] = busy;
    end
    for (int k = 0; k < 8; k++) begin
      chk("t1_valid", 64'(ov[k]), 64'(k >= 3 && k <= 5));
      chk("t1_busy", 64'(bz[k]), 64'(k >= 1 && k <= 5));
    end
    wait_drain(20);

    // All lanes full: expected lane order derived from per-lane counts.
    do_reset();
    for (int l = 0; l < NL; l++) begin push_words(l, 10); cnt[l] = 10; end
    r = 0; left = 10 * NL;
    while (left > 0) begin
      if (cnt[r] > 0) begin
        n = (cnt[r] < BM) ? cnt[r] : BM;
        for (int i = 0; i < n; i++) lane_ord.push_back(r);
        cnt[r] -= n; left -= n;
      end
      r = (r + 1) % NL;
    end
    chk_ord = 1'b1;
    tick();
    en = 1'b1;
    wait_drain(400);
    chk("t2_ord_left", 64'(lane_ord.size()), 0);
    chk("t2_count", 64'(deq_total), 40);
    chk_ord = 1'b0;

    // Backpressure: only two words may be outstanding.
    do_reset();
    out_ready = 1'b0;
    push_words(0, 8);
    tick();
    en = 1'b1;
    repeat (10) tick();
    chk("t3_pops", 64'(pop_total), 2);
    @(negedge hs_clk);
    chk("t3_valid", 64'(out_valid), 1);
    tick();
    out_ready = 1'b1;
    wait_drain(100);
    chk("t3_total", 64'(deq_total), 8);

    // Masked lanes are never granted.
    do_reset();
    lane_mask = 4'b1010;
    for (int l = 0; l < NL; l++) push_words(l, 5);
    tick();
    en = 1'b1;
    repeat (60) tick();
    chk("t4_lane0", 64'(pop_cnt[0]), 0);
    chk("t4_lane2", 64'(pop_cnt[2]), 0);
    chk("t4_lane1", 64'(pop_cnt[1]), 5);
    chk("t4_lane3", 64'(pop_cnt[3]), 5);
    lane_mask = '1;
    wait_drain(100);

    // Enable dropped after the second pop of a burst.
    do_reset();
    for (int l = 0; l < NL; l++) push_words(l, 4);
    tick();
    en = 1'b1;
    for (int i = 0; i < 20 && pop_total < 2; i++) tick();
    en = 1'b0;
    repeat (8) tick();
    @(negedge hs_clk);
    chk("t5_pops", 64'(pop_total), 2);
    chk("t5_delivered", 64'(deq_total), 2);
    chk("t5_busy", 64'(busy), 0);
    tick();
    en = 1'b1;
    for (int i = 0; i < 20 && pop_total < 3; i++) tick();
    chk("t5_next_lane", 64'(last_pop_lane), 1);
    wait_drain(200);

    // Reset with words buffered and in flight; pointer returns to lane 0.
    do_reset();
    out_ready = 1'b0;
    push_words(0, 1);
    push_words(1, 8);
    tick();
    en = 1'b1;
    repeat (12) tick();
    chk("t6_outstanding", 64'(exp_q.size()), 2);
    rst = 1'b1;
    tick();
    @(negedge hs_clk);
    chk("t6_valid", 64'(out_valid), 0);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_pop", 64'(fifo_pop), 0);
    chk("t6_data", 64'(out_data), 0);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    push_words(0, 2);
    p = pop_total;
    for (int i = 0; i < 20 && pop_total == p; i++) tick();
    chk("t6_first_lane", 64'(last_pop_lane), 0);
    wait_drain(200);

    // Random soak.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      en        = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) lane_mask = NL'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        rl = $urandom_range(0, NL - 1);
        if (lane_q[rl].size() < 12) push_words(rl, $urandom_range(1, 3));
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; en = 1'b1; lane_mask = '1; out_ready = 1'b1;
    wait_drain(1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
